// File: rtl/imem_loader.sv
// imem_loader
// Boot-time loader for the word-addressed instruction RAM. The loader holds the
// processor in reset, accepts an image as a valid/ready word stream, writes it
// into the RAM starting at word 0, and then releases the processor. Once the
// processor is running, no further writes are accepted until a reload
// (ld_start) is requested.
//
// Ports:
//   clk, reset          system clock; synchronous active-high reset
//   ld_start            single-cycle (re)load request; wins over a same-cycle beat
//   ld_valid/ld_ready   beat handshake; ld_data is the word, ld_last marks the end
//   mem_we/mem_waddr/mem_wdata  registered RAM write port, one cycle after accept
//   cpu_reset           registered processor reset, low only in RUN
//   done                image loaded and processor released
//   ovf                 sticky: image filled DEPTH words with no ld_last
//   err                 sticky: checksum mismatch (tied 0 without checksum)
//   word_count          number of image words written (saturates at DEPTH)
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// checksum word (32-bit wrapping sum of the image) and to enable the CHECK and
// ERROR states.
module imem_loader #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_reset,
  output logic          done,
  output logic          ovf,
  output logic          err,
  output logic [AW:0]   word_count
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_LOAD, S_CHECK, S_DRAIN, S_RUN, S_ERROR} state_t;
`else
  typedef enum logic [2:0] {S_LOAD, S_DRAIN, S_RUN} state_t;
`endif

  state_t      state, state_next;
  logic [AW:0] addr;
  logic        accept;
  logic        at_end;
  logic        load_beat;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum;
  logic        err_q;
`endif

  assign at_end     = (addr == (AW+1)'(DEPTH - 1));
  assign accept     = ld_valid && ld_ready;
  assign load_beat  = accept && (state == S_LOAD);
  assign word_count = addr;

  // Ready is kept apart from the next-state logic so that accept never feeds
  // back into the block that produces ld_ready.
  always_comb begin
    ld_ready = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (state == S_LOAD || state == S_CHECK) ld_ready = !ld_start;
`else
    if (state == S_LOAD) ld_ready = !ld_start;
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      S_LOAD: begin
        // Filling the last RAM word ends the image as if ld_last were seen.
        if (accept && (ld_last || at_end)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = S_CHECK;
`else
          state_next = S_DRAIN;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) state_next = (ld_data == sum) ? S_DRAIN : S_ERROR;
      end
`endif
      S_DRAIN: state_next = S_RUN;
      default: ;
    endcase
    if (ld_start) state_next = S_LOAD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_LOAD;
      addr      <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      ovf       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum       <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      mem_we    <= 1'b0;
      cpu_reset <= (state_next != S_RUN);
      done      <= (state_next == S_RUN);
      if (ld_start) begin
        addr <= '0;
        ovf  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum   <= '0;
        err_q <= 1'b0;
`endif
      end else if (load_beat) begin
        // addr only advances in LOAD, which is left on the DEPTH-1 beat, so
        // it tops out at DEPTH without an explicit saturation check.
        mem_we    <= 1'b1;
        mem_waddr <= addr[AW-1:0];
        mem_wdata <= ld_data;
        addr      <= addr + 1'b1;
        if (at_end && !ld_last) ovf <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum <= sum + ld_data;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      else if (accept && state == S_CHECK && ld_data != sum) begin
        err_q <= 1'b1;
      end
`endif
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader. The reference model tracks the image as a word
// count and a running sum; every cycle the expected RAM write, handshake and
// release outputs are derived from those.
module tb_imem_loader;
  localparam int DEPTH = 512;
  localparam int AW    = 9;

  logic          clk, reset, ld_start, ld_valid, ld_last;
  logic [31:0]   ld_data;
  logic          ld_ready, mem_we, cpu_reset, done, ovf, err;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   word_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_count;
  logic [31:0] m_sum;
  bit          m_ovf;
  bit          m_ended;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .cpu_reset(cpu_reset),
    .done(done), .ovf(ovf), .err(err), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    m_count = 0; m_sum = '0; m_ovf = 0; m_ended = 0;
  endtask

  task automatic test_reset();
    reset = 1; ld_start = 0; ld_valid = 0; ld_last = 0; ld_data = $urandom;
    @(posedge clk); #1;
    reset = 0;
    model_clear();
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", mem_we); end
    n_checks++; if (mem_waddr !== '0) begin n_fail++; $display("FAIL reset_waddr got %0d want 0", mem_waddr); end
    n_checks++; if (mem_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", mem_wdata); end
    n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_reset got %b want 1", cpu_reset); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_checks++; if (word_count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", word_count); end
    #1;
    n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ld_ready); end
  endtask

  // One image word, preceded by 'gaps' idle cycles (ld_last is noise there).
  task automatic send_word(input logic [31:0] w, input bit last, input int gaps);
    for (int g = 0; g < gaps; g++) begin
      ld_valid = 0; ld_data = $urandom; ld_last = 1'($urandom);
      #1;
      n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL gap_ready got %b want 1", ld_ready); end
      @(posedge clk); #1;
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL gap_we got %b want 0", mem_we); end
    end
    ld_valid = 1; ld_data = w; ld_last = last;
    #1;
    n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL beat_ready got %b want 1", ld_ready); end
    @(posedge clk); #1;
    ld_valid = 0; ld_last = 0;
    n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL beat_we got %b want 1", mem_we); end
    n_checks++; if (mem_waddr !== AW'(m_count)) begin n_fail++; $display("FAIL beat_addr got %0d want %0d", mem_waddr, m_count); end
    n_checks++; if (mem_wdata !== w) begin n_fail++; $display("FAIL beat_data got %h want %h", mem_wdata, w); end
    m_count++;
    m_sum += w;
    if (last) m_ended = 1;
    else if (m_count == DEPTH) begin m_ended = 1; m_ovf = 1; end
    n_checks++; if (word_count !== (AW+1)'(m_count)) begin n_fail++; $display("FAIL beat_count got %0d want %0d", word_count, m_count); end
    n_checks++; if (ovf !== m_ovf) begin n_fail++; $display("FAIL beat_ovf got %b want %b", ovf, m_ovf); end
    n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL beat_cpu_reset got %b want 1", cpu_reset); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic send_checksum(input logic [31:0] ck);
    bit bad;
    bad = (ck != m_sum);
    ld_valid = 1; ld_data = ck; ld_last = 0;
    #1;
    n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL ck_ready got %b want 1", ld_ready); end
    @(posedge clk); #1;
    ld_valid = 0;
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL ck_we got %b want 0", mem_we); end
    n_checks++; if (err !== bad) begin n_fail++; $display("FAIL ck_err got %b want %b", err, bad); end
    if (bad) begin
      for (int i = 0; i < 3; i++) begin
        ld_valid = 1; ld_data = $urandom;
        #1;
        n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL error_ready got %b want 0", ld_ready); end
        @(posedge clk); #1;
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL error_we got %b want 0", mem_we); end
        n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL error_cpu_reset got %b want 1", cpu_reset); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL error_done got %b want 0", done); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL error_err got %b want 1", err); end
      end
      ld_valid = 0;
    end
  endtask
`endif

  // Called once the final image beat (or the checksum beat) has been accepted.
  task automatic check_drain();
    ld_valid = 0; ld_last = 0;
    #1;
    n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL drain_cpu_reset got %b want 1", cpu_reset); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL drain_done got %b want 0", done); end
    n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL drain_ready got %b want 0", ld_ready); end
    @(posedge clk); #1;
    n_checks++; if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL run_cpu_reset got %b want 0", cpu_reset); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL run_done got %b want 1", done); end
    n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL run_ready got %b want 0", ld_ready); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL run_we got %b want 0", mem_we); end
    n_checks++; if (word_count !== (AW+1)'(m_count)) begin n_fail++; $display("FAIL run_count got %0d want %0d", word_count, m_count); end
    n_checks++; if (ovf !== m_ovf) begin n_fail++; $display("FAIL run_ovf got %b want %b", ovf, m_ovf); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL run_err got %b want 0", err); end
  endtask

  task automatic finish_image();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_checksum(m_sum);
`endif
    check_drain();
  endtask

  // ld_start offered together with a beat: the beat must be refused.
  task automatic start_load();
    ld_start = 1; ld_valid = 1; ld_data = $urandom; ld_last = 1;
    #1;
    n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL start_ready got %b want 0", ld_ready); end
    @(posedge clk); #1;
    ld_start = 0; ld_valid = 0; ld_last = 0;
    model_clear();
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL start_we got %b want 0", mem_we); end
    n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL start_cpu_reset got %b want 1", cpu_reset); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL start_done got %b want 0", done); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL start_ovf got %b want 0", ovf); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL start_err got %b want 0", err); end
    n_checks++; if (word_count !== '0) begin n_fail++; $display("FAIL start_count got %0d want 0", word_count); end
  endtask

  task automatic test_back_to_back();
    send_word(32'hE3A000AA, 0, 0);
    send_word(32'hE3A01055, 0, 0);
    send_word(32'hEAFFFFFE, 1, 0);
    finish_image();
  endtask

  task automatic test_gapped();
    start_load();
    send_word(32'hE3A000AA, 0, 2);
    send_word(32'hE3A01055, 0, 2);
    send_word(32'hEAFFFFFE, 1, 2);
    finish_image();
  endtask

  task automatic test_random_images();
    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(1, 12);
      start_load();
      for (int i = 0; i < n; i++) send_word($urandom, (i == n - 1), $urandom_range(0, 3));
      finish_image();
    end
  endtask

  task automatic test_overflow();
    start_load();
    for (int i = 0; i < DEPTH + 4 && !m_ended; i++) send_word($urandom, 0, $urandom_range(0, 1));
    finish_image();
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1; ld_data = $urandom; ld_last = 1;
      #1;
      n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_extra_ready got %b want 0", ld_ready); end
      @(posedge clk); #1;
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL ovf_extra_we got %b want 0", mem_we); end
      n_checks++; if (word_count !== (AW+1)'(DEPTH)) begin n_fail++; $display("FAIL ovf_extra_count got %0d want %0d", word_count, DEPTH); end
    end
    ld_valid = 0; ld_last = 0;
  endtask

  task automatic test_reload();
    start_load();
    #1;
    n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reload_ready got %b want 1", ld_ready); end
    send_word($urandom, 0, 0);
    send_word($urandom, 1, 1);
    finish_image();
  endtask

  task automatic test_reset_midload();
    start_load();
    send_word($urandom, 0, 0);
    send_word($urandom, 0, 1);
    test_reset();
    send_word($urandom, 0, 0);
    send_word($urandom, 0, 0);
    send_word($urandom, 1, 0);
    finish_image();
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    start_load();
    send_word(32'h00000001, 0, 0);
    send_word(32'h00000002, 1, 0);
    send_checksum(32'h00000003);
    check_drain();
    start_load();
    send_word(32'h00000001, 0, 0);
    send_word(32'h00000002, 1, 1);
    send_checksum(32'h00000004);
    start_load();
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped();
    test_random_images();
    test_overflow();
    test_reload();
    test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached without completing the sequence");
    $fatal(1, "timeout");
  end

endmodule
